inst_fetch: RTL and testbench

- Instruction-fetch stage directly downstream of the PC unit.
- Takes the current pc and issues a fetch on an SRAM-like instruction bus (req / addr_ok / data_ok).
- Buffers the returned word and loads the IF/ID pipeline register.
- Drives the PC unit's stall input so pc advances only when an instruction is handed to decode.
- Discards in-flight fetches on redirect (exception, eret, branch, jump).

---
 rtl/inst_fetch.sv | 101 ++++++++++
 tb/tb_inst_fetch.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// Instruction fetch: issues one SRAM-style request per pc, buffers the returned word and loads IF/ID.
// Holds the PC unit via fetchStall until decode accepts the word; redirects squash in-flight fetches.
module inst_fetch #(
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        flush,
    input  logic        idStall,
    output logic        fetchStall,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic        idValid,
    output logic [31:0] idPc,
    output logic [31:0] idInst,
    output logic        idExcAdel
);

    typedef enum logic [1:0] {REQ, WAIT, HOLD, DISCARD} state_t;

    state_t      state;
    logic [31:0] holdInst;
    logic        misaligned;
    logic        adelSlot;
    logic        load;

    assign misaligned = (pc[1:0] != 2'b00);
    assign adelSlot   = (state == REQ) && misaligned;
    assign inst_req   = (state == REQ) && !misaligned && !flush;
    assign inst_addr  = pc;

    // A load hands a word to decode; that is also the only non-redirect cycle pc may advance.
    assign load = !flush && !idStall &&
                  (adelSlot || (state == WAIT && inst_data_ok) || (state == HOLD));
    assign fetchStall = !(load || flush);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= REQ;
            holdInst  <= 32'h0;
            idValid   <= 1'b0;
            idPc      <= 32'h0;
            idInst    <= NOP_INST;
            idExcAdel <= 1'b0;
        end else begin
            case (state)
                REQ: begin
                    if (inst_req && inst_addr_ok)
                        state <= WAIT;
                end
                WAIT: begin
                    if (inst_data_ok) begin
                        if (!flush && idStall) begin
                            holdInst <= inst_rdata;
                            state    <= HOLD;
                        end else begin
                            state <= REQ;
                        end
                    end else if (flush) begin
                        state <= DISCARD;
                    end
                end
                HOLD: begin
                    if (flush || !idStall)
                        state <= REQ;
                end
                DISCARD: begin
                    // The squashed request still owes us one response; swallow it.
                    if (inst_data_ok)
                        state <= REQ;
                end
                default: state <= REQ;
            endcase

            if (flush) begin
                idValid   <= 1'b0;
                idInst    <= NOP_INST;
                idExcAdel <= 1'b0;
            end else if (load) begin
                idValid   <= 1'b1;
                idPc      <= pc;
                idExcAdel <= adelSlot;
                if (adelSlot)
                    idInst <= NOP_INST;
                else if (state == WAIT)
                    idInst <= inst_rdata;
                else
                    idInst <= holdInst;
            end else if (!idStall) begin
                idValid   <= 1'b0;
                idInst    <= NOP_INST;
                idExcAdel <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: inputs change 1ns after a rising edge, outputs checked before the next.
module tb_inst_fetch;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic        flush;
    logic        idStall;
    logic        fetchStall;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        idValid;
    logic [31:0] idPc;
    logic [31:0] idInst;
    logic        idExcAdel;

    int checks   = 0;
    int failures = 0;

    inst_fetch #(.NOP_INST(32'h0000_0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .flush       (flush),
        .idStall     (idStall),
        .fetchStall  (fetchStall),
        .inst_req    (inst_req),
        .inst_addr   (inst_addr),
        .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok),
        .inst_rdata  (inst_rdata),
        .idValid     (idValid),
        .idPc        (idPc),
        .idInst      (idInst),
        .idExcAdel   (idExcAdel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    initial begin
        logic [31:0] words [3];
        words[0] = 32'h3C08_BFC0;
        words[1] = 32'h2508_0010;
        words[2] = 32'h0100_0008;

        rst = 1'b1; pc = 32'hBFC0_0000; flush = 1'b0; idStall = 1'b0;
        inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = 32'h0;
        tick;
        chk("rst_idValid", idValid, 0);
        chk("rst_idPc", idPc, 0);
        chk("rst_idInst", idInst, 0);
        chk("rst_idExcAdel", idExcAdel, 0);
        rst = 1'b0;

        // Zero-wait back-to-back fetches.
        for (int i = 0; i < 3; i++) begin
            pc = 32'hBFC0_0000 + 32'(i * 4);
            inst_addr_ok = 1'b1; inst_data_ok = 1'b0;
            settle;
            chk("b2b_req", inst_req, 1);
            chk("b2b_addr", inst_addr, 32'hBFC0_0000 + 32'(i * 4));
            chk("b2b_stall_req", fetchStall, 1);
            tick;
            chk("b2b_bubble", idValid, 0);
            inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = words[i];
            settle;
            chk("b2b_req_wait", inst_req, 0);
            chk("b2b_stall_data", fetchStall, 0);
            tick;
            chk("b2b_valid", idValid, 1);
            chk("b2b_pc", idPc, 32'hBFC0_0000 + 32'(i * 4));
            chk("b2b_inst", idInst, words[i]);
        end

        // Decode stall while data returns: word parks in the hold buffer.
        pc = 32'hBFC0_000C; inst_addr_ok = 1'b1; inst_data_ok = 1'b0;
        tick;
        inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h2408_0001; idStall = 1'b1;
        settle;
        chk("hold_stall_data", fetchStall, 1);
        tick;
        inst_data_ok = 1'b0;
        for (int i = 0; i < 2; i++) begin
            settle;
            chk("hold_stall", fetchStall, 1);
            chk("hold_noreq", inst_req, 0);
            chk("hold_idInst", idInst, 0);
            chk("hold_idPc", idPc, 32'hBFC0_0008);
            tick;
        end
        idStall = 1'b0;
        settle;
        chk("hold_release_stall", fetchStall, 0);
        tick;
        chk("hold_valid", idValid, 1);
        chk("hold_inst", idInst, 32'h2408_0001);
        chk("hold_pc", idPc, 32'hBFC0_000C);
        pc = 32'hBFC0_0010;
        settle;
        chk("hold_rereq", inst_req, 1);

        // Redirect while waiting: stale response must be dropped.
        inst_addr_ok = 1'b1;
        tick;
        inst_addr_ok = 1'b0; flush = 1'b1;
        settle;
        chk("disc_flush_stall", fetchStall, 0);
        chk("disc_flush_noreq", inst_req, 0);
        tick;
        chk("disc_valid0", idValid, 0);
        flush = 1'b0; pc = 32'hBFC0_0380;
        settle;
        chk("disc_noreq", inst_req, 0);
        chk("disc_stall", fetchStall, 1);
        tick;
        inst_data_ok = 1'b1; inst_rdata = 32'hDEAD_BEEF;
        settle;
        chk("disc_stale_stall", fetchStall, 1);
        tick;
        chk("disc_stale_valid", idValid, 0);
        chk("disc_stale_inst", idInst, 0);
        inst_data_ok = 1'b0;
        settle;
        chk("disc_newreq", inst_req, 1);
        chk("disc_newaddr", inst_addr, 32'hBFC0_0380);
        inst_addr_ok = 1'b1;
        tick;
        inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h4008_6000;
        tick;
        chk("disc_vec_pc", idPc, 32'hBFC0_0380);
        chk("disc_vec_inst", idInst, 32'h4008_6000);

        // Flush coincident with data_ok: no DISCARD, straight back to REQ.
        pc = 32'hBFC0_0384; inst_data_ok = 1'b0; inst_addr_ok = 1'b1;
        tick;
        inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h1111_2222; flush = 1'b1;
        settle;
        chk("fd_stall", fetchStall, 0);
        tick;
        chk("fd_valid", idValid, 0);
        chk("fd_inst", idInst, 0);
        inst_data_ok = 1'b0; flush = 1'b0; pc = 32'hBFC0_0380;
        settle;
        chk("fd_req_next", inst_req, 1);

        // Misaligned pc: address-error slot without a bus request.
        pc = 32'hBFC0_0002; idStall = 1'b1;
        settle;
        chk("adel_noreq", inst_req, 0);
        chk("adel_stalled", fetchStall, 1);
        idStall = 1'b0;
        settle;
        chk("adel_stall", fetchStall, 0);
        tick;
        chk("adel_exc", idExcAdel, 1);
        chk("adel_valid", idValid, 1);
        chk("adel_inst", idInst, 0);
        chk("adel_pc", idPc, 32'hBFC0_0002);

        // Asynchronous reset in the middle of WAIT.
        pc = 32'hBFC0_0000; idStall = 1'b1; inst_addr_ok = 1'b1;
        tick;
        chk("arst_pre_valid", idValid, 1);
        inst_addr_ok = 1'b0; idStall = 1'b0;
        settle;
        chk("arst_wait_noreq", inst_req, 0);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", idValid, 0);
        chk("arst_exc", idExcAdel, 0);
        chk("arst_pc", idPc, 0);
        chk("arst_req", inst_req, 1);
        tick;
        rst = 1'b0;
        settle;
        chk("arst_rel_req", inst_req, 1);
        pc = 32'hBFC0_0001;
        settle;
        chk("arst_rel_misalign", inst_req, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
